alu_exec_seq: RTL and testbench
===============================

Name: alu_exec_seq

Overview:
Execute-stage sequencer directly upstream of the 8-bit ALU. Accepts one instruction per valid/ready handshake and reads both source registers from an internal register file. Drives the ALU operand and operation inputs, captures the ALU result and carry, then writes the result back and updates the flags. The ALU itself stays an external combinational instance; this block owns all state around it.

Parameters:
DATA_W, 8, datapath width; must equal the ALU width (8).
REG_ADDR_W, 2, register-address width; register file has 2**REG_ADDR_W entries (r0..r3).

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  instruction present
in_ready  output  1  block can accept an instruction (high only in IDLE)
in_op  input  4  opcode
in_rd  input  REG_ADDR_W  destination register
in_rs1  input  REG_ADDR_W  source 1 register
in_rs2  input  REG_ADDR_W  source 2 register
in_imm  input  DATA_W  immediate for LDI
alu_operand1  output  DATA_W  to ALU operand1
alu_operand2  output  DATA_W  to ALU operand2
alu_operation  output  4  to ALU operation
alu_result  input  DATA_W  from ALU result
alu_carry  input  1  from ALU carry_out
done  output  1  one-cycle pulse, instruction retired
done_data  output  DATA_W  value written to rd (0 when no write)
flag_z  output  1  zero flag
flag_c  output  1  carry flag
err  output  1  sticky error flag
dbg_addr  input  REG_ADDR_W  debug read address
dbg_data  output  DATA_W  combinational read of regfile[dbg_addr]

Behaviour:
- Reset (rst_n low at a clk edge): state IDLE; all registers 0; operand latches 0; flag_z, flag_c, err, done, done_data all 0; alu_operation 0. Reset mid-instruction aborts it: no writeback, no done pulse.
- Opcodes:
  - 0000 ADD, 0001 SUB, 0010 MUL (low 8 bits), 0011 DIV, 0100 AND, 0101 OR, 0110 XOR: ALU ops; opcode is passed unchanged to alu_operation.
  - 1000 LDI: rd <= in_imm.
  - 1001 MOV: rd <= rs1.
  - All other codes are illegal.
- FSM states IDLE -> EXEC -> WB -> IDLE.
  - IDLE: in_ready=1. On in_valid at edge T: latch op and rd; latch regfile[rs1] and regfile[rs2] (LDI: in_imm) into operand registers; go to EXEC.
  - EXEC (T..T+1): alu_operand1/2 and alu_operation are driven from the latches. At edge T+1, capture alu_result and alu_carry into a result register; go to WB. For LDI/MOV/illegal, capture the latched source or imm instead.
  - WB (T+1..T+2): done=1 and done_data=result during this cycle. At edge T+2, write regfile[rd] and update flags; go to IDLE.
- Latency 2 cycles from acceptance to done. Throughput is one instruction per 3 cycles. in_ready is 0 in EXEC and WB; in_valid is ignored there.
- No hazards: the next instruction is read only after writeback.
- Flags:
  - flag_z = (result==0), updated on ALU ops, LDI and MOV.
  - flag_c updated only on ADD, from the captured alu_carry; held on all other ops.
- DIV with operand2==0: the ALU output is not used; no register write; flags held; err<=1; done still pulses with done_data=0.
- Illegal opcode: no register write; flags held; err<=1; done pulses with done_data=0.
- err is cleared only by reset.
- outputs to the ALU are held stable throughout EXEC; outside EXEC they keep their last latched values.
- rd equal to rs1 or rs2 is legal: sources are read before the write.

Test Plan:
- Reset, then LDI r1=0x05, LDI r2=0x03, ADD r3=r1+r2 -> three done pulses, 3 cycles apart; done_data 0x05, 0x03, 0x08; r3=0x08; flag_c=0; flag_z=0.
- LDI r0=0xFF, LDI r1=0x01, ADD r2=r0+r1 -> r2=0x00, flag_z=1, flag_c=1; then a following AND holds flag_c=1.
- SUB, MUL, DIV, XOR on r1=0x0C, r2=0x04 -> 0x08, 0x30, 0x03, 0x08 respectively; alu_operation matches the opcode during EXEC.
- DIV r3=r1/r0 with r0=0 -> err=1, r3 unchanged, done_data=0; opcode 1111 -> err stays 1, no write.
- in_valid held high continuously -> in_ready low in EXEC and WB; exactly one acceptance per 3 cycles; no instruction is lost or duplicated.
- rst_n low during EXEC of ADD -> no done pulse, regfile all 0, flags 0, in_ready=1 on the cycle after reset deasserts.

Source files
------------

// File: rtl/alu_exec_seq.sv
// Execute-stage sequencer around an external combinational 8-bit ALU.
// Owns the register file, operand latches, result capture, writeback and flags.
module alu_exec_seq #(
  parameter int unsigned DATA_W     = 8,
  parameter int unsigned REG_ADDR_W = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [3:0]            in_op,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [DATA_W-1:0]     in_imm,
  output logic [DATA_W-1:0]     alu_operand1,
  output logic [DATA_W-1:0]     alu_operand2,
  output logic [3:0]            alu_operation,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_carry,
  output logic                  done,
  output logic [DATA_W-1:0]     done_data,
  output logic                  flag_z,
  output logic                  flag_c,
  output logic                  err,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
);

  localparam int unsigned NREG = 1 << REG_ADDR_W;

  localparam logic [3:0] OP_ADD = 4'b0000;
  localparam logic [3:0] OP_DIV = 4'b0011;
  localparam logic [3:0] OP_XOR = 4'b0110;
  localparam logic [3:0] OP_LDI = 4'b1000;
  localparam logic [3:0] OP_MOV = 4'b1001;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXEC,
    S_WB
  } state_e;

  state_e                  state_q, state_d;
  logic [3:0]              op_q, op_d;
  logic [REG_ADDR_W-1:0]   rd_q, rd_d;
  logic [DATA_W-1:0]       opa_q, opa_d;
  logic [DATA_W-1:0]       opb_q, opb_d;
  logic [DATA_W-1:0]       res_q, res_d;
  logic                    carry_q, carry_d;
  logic                    wr_q, wr_d;
  logic                    flag_z_q, flag_z_d;
  logic                    flag_c_q, flag_c_d;
  logic                    err_q, err_d;
  logic [DATA_W-1:0]       rf_q [NREG];
  logic [DATA_W-1:0]       rf_d [NREG];

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    rd_d     = rd_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    res_d    = res_q;
    carry_d  = carry_q;
    wr_d     = wr_q;
    flag_z_d = flag_z_q;
    flag_c_d = flag_c_q;
    err_d    = err_q;
    rf_d     = rf_q;

    unique case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d    = in_op;
          rd_d    = in_rd;
          opa_d   = (in_op == OP_LDI) ? in_imm : rf_q[in_rs1];
          opb_d   = rf_q[in_rs2];
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        carry_d = alu_carry;
        state_d = S_WB;
        if (op_q <= OP_XOR) begin
          // Divide by zero discards the ALU output and retires with zero data.
          if (op_q == OP_DIV && opb_q == '0) begin
            res_d = '0;
            wr_d  = 1'b0;
          end else begin
            res_d = alu_result;
            wr_d  = 1'b1;
          end
        end else if (op_q == OP_LDI || op_q == OP_MOV) begin
          res_d = opa_q;
          wr_d  = 1'b1;
        end else begin
          res_d = '0;
          wr_d  = 1'b0;
        end
      end
      S_WB: begin
        state_d = S_IDLE;
        if (wr_q) begin
          rf_d[rd_q] = res_q;
          flag_z_d   = (res_q == '0);
          if (op_q == OP_ADD) flag_c_d = carry_q;
        end else begin
          err_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      rd_q     <= '0;
      opa_q    <= '0;
      opb_q    <= '0;
      res_q    <= '0;
      carry_q  <= 1'b0;
      wr_q     <= 1'b0;
      flag_z_q <= 1'b0;
      flag_c_q <= 1'b0;
      err_q    <= 1'b0;
      rf_q     <= '{default: '0};
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      rd_q     <= rd_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      res_q    <= res_d;
      carry_q  <= carry_d;
      wr_q     <= wr_d;
      flag_z_q <= flag_z_d;
      flag_c_q <= flag_c_d;
      err_q    <= err_d;
      rf_q     <= rf_d;
    end
  end

  assign in_ready      = (state_q == S_IDLE);
  assign done          = (state_q == S_WB);
  assign done_data     = done ? res_q : '0;
  assign alu_operand1  = opa_q;
  assign alu_operand2  = opb_q;
  assign alu_operation = op_q;
  assign flag_z        = flag_z_q;
  assign flag_c        = flag_c_q;
  assign err           = err_q;
  assign dbg_data      = rf_q[dbg_addr];

endmodule

// File: tb/tb_alu_exec_seq.sv
// Bench for alu_exec_seq: behavioural ALU plus an arithmetic reference model,
// directed steps followed by randomized instructions.
module tb_alu_exec_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [3:0] in_op;
  logic [1:0] in_rd, in_rs1, in_rs2;
  logic [7:0] in_imm;
  logic [7:0] alu_operand1, alu_operand2;
  logic [3:0] alu_operation;
  logic [7:0] alu_result;
  logic       alu_carry;
  logic       done;
  logic [7:0] done_data;
  logic       flag_z, flag_c, err;
  logic [1:0] dbg_addr;
  logic [7:0] dbg_data;

  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned done_cnt = 0;
  int unsigned instr_cnt = 0;

  logic [7:0] ref_rf [4];
  logic       ref_z, ref_c, ref_err;

  alu_exec_seq #(.DATA_W(8), .REG_ADDR_W(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .alu_operand1(alu_operand1), .alu_operand2(alu_operand2), .alu_operation(alu_operation),
    .alu_result(alu_result), .alu_carry(alu_carry),
    .done(done), .done_data(done_data),
    .flag_z(flag_z), .flag_c(flag_c), .err(err),
    .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #5 clk = ~clk;

  // External ALU: divide by zero returns junk the sequencer must ignore.
  always_comb begin
    logic [8:0] t;
    t = '0;
    case (alu_operation)
      4'd0: t = {1'b0, alu_operand1} + {1'b0, alu_operand2};
      4'd1: t = {1'b0, alu_operand1} - {1'b0, alu_operand2};
      4'd2: t = {1'b0, alu_operand1 * alu_operand2};
      4'd3: t = (alu_operand2 == 8'd0) ? 9'h1AA : {1'b0, alu_operand1 / alu_operand2};
      4'd4: t = {1'b0, alu_operand1 & alu_operand2};
      4'd5: t = {1'b0, alu_operand1 | alu_operand2};
      4'd6: t = {1'b0, alu_operand1 ^ alu_operand2};
      default: t = 9'h155;
    endcase
    alu_result = t[7:0];
    alu_carry  = t[8];
  end

  always @(posedge clk) if (rst_n && done) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    chk({tag, ".ready"}, 32'(in_ready), 32'd1);
    chk({tag, ".done"}, 32'(done), 32'd0);
    chk({tag, ".z"}, 32'(flag_z), 32'(ref_z));
    chk({tag, ".c"}, 32'(flag_c), 32'(ref_c));
    chk({tag, ".err"}, 32'(err), 32'(ref_err));
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk($sformatf("%s.r%0d", tag, i), 32'(dbg_data), 32'(ref_rf[i]));
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) ref_rf[i] = 8'h00;
    ref_z = 1'b0; ref_c = 1'b0; ref_err = 1'b0;
  endtask

  // Called just after a clock edge with the DUT idle; returns just after the
  // edge that completes writeback.
  task automatic do_instr(input string tag, input logic [3:0] op, input logic [1:0] rd,
                          input logic [1:0] rs1, input logic [1:0] rs2,
                          input logic [7:0] imm, input bit hold);
    logic [7:0] a, b, res;
    logic       c, wr;
    a = ref_rf[rs1]; b = ref_rf[rs2];
    res = 8'h00; c = 1'b0; wr = 1'b1;
    case (op)
      4'd0: {c, res} = {1'b0, a} + {1'b0, b};
      4'd1: res = a - b;
      4'd2: res = a * b;
      4'd3: if (b == 8'd0) wr = 1'b0; else res = a / b;
      4'd4: res = a & b;
      4'd5: res = a | b;
      4'd6: res = a ^ b;
      4'd8: res = imm;
      4'd9: res = a;
      default: wr = 1'b0;
    endcase
    if (!wr) res = 8'h00;
    instr_cnt++;

    in_valid = 1'b1; in_op = op; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    @(posedge clk); #1;
    if (!hold) in_valid = 1'b0;
    chk({tag, ".exec_ready"}, 32'(in_ready), 32'd0);
    chk({tag, ".exec_done"}, 32'(done), 32'd0);
    if (op <= 4'd6) begin
      chk({tag, ".alu_op"}, 32'(alu_operation), 32'(op));
      chk({tag, ".alu_a"}, 32'(alu_operand1), 32'(a));
      chk({tag, ".alu_b"}, 32'(alu_operand2), 32'(b));
    end
    @(posedge clk); #1;
    chk({tag, ".wb_ready"}, 32'(in_ready), 32'd0);
    chk({tag, ".wb_done"}, 32'(done), 32'd1);
    chk({tag, ".wb_data"}, 32'(done_data), 32'(res));
    @(posedge clk); #1;
    if (wr) begin
      ref_rf[rd] = res;
      ref_z = (res == 8'h00);
      if (op == 4'd0) ref_c = c;
    end else begin
      ref_err = 1'b1;
    end
    if (!hold) chk_state(tag);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_op = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0;
    in_imm = '0; dbg_addr = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset.operation", 32'(alu_operation), 32'd0);
    chk("reset.done_data", 32'(done_data), 32'd0);
    chk_state("reset");
    rst_n = 1'b1;

    // Basic load and add
    do_instr("ldi_r1", 4'd8, 2'd1, 2'd0, 2'd0, 8'h05, 1'b0);
    do_instr("ldi_r2", 4'd8, 2'd2, 2'd0, 2'd0, 8'h03, 1'b0);
    do_instr("add_r3", 4'd0, 2'd3, 2'd1, 2'd2, 8'h00, 1'b0);
    chk("add_r3.value", 32'(ref_rf[3]), 32'h08);

    // Overflow to zero with carry, then carry held across AND
    do_instr("ldi_ff", 4'd8, 2'd0, 2'd0, 2'd0, 8'hFF, 1'b0);
    do_instr("ldi_01", 4'd8, 2'd1, 2'd0, 2'd0, 8'h01, 1'b0);
    do_instr("add_wrap", 4'd0, 2'd2, 2'd0, 2'd1, 8'h00, 1'b0);
    chk("add_wrap.c", 32'(flag_c), 32'd1);
    do_instr("and_hold", 4'd4, 2'd3, 2'd0, 2'd1, 8'h00, 1'b0);
    chk("and_hold.c", 32'(flag_c), 32'd1);

    // ALU ops on 0x0C and 0x04
    do_instr("ldi_0c", 4'd8, 2'd1, 2'd0, 2'd0, 8'h0C, 1'b0);
    do_instr("ldi_04", 4'd8, 2'd2, 2'd0, 2'd0, 8'h04, 1'b0);
    do_instr("sub", 4'd1, 2'd3, 2'd1, 2'd2, 8'h00, 1'b0);
    do_instr("mul", 4'd2, 2'd3, 2'd1, 2'd2, 8'h00, 1'b0);
    do_instr("div", 4'd3, 2'd3, 2'd1, 2'd2, 8'h00, 1'b0);
    do_instr("xor", 4'd6, 2'd3, 2'd1, 2'd2, 8'h00, 1'b0);
    do_instr("mov", 4'd9, 2'd0, 2'd1, 2'd0, 8'h00, 1'b0);

    // Divide by zero, then illegal opcode
    do_instr("ldi_zero", 4'd8, 2'd0, 2'd0, 2'd0, 8'h00, 1'b0);
    do_instr("div_zero", 4'd3, 2'd3, 2'd1, 2'd0, 8'h00, 1'b0);
    do_instr("illegal", 4'hF, 2'd3, 2'd1, 2'd2, 8'h00, 1'b0);

    // Back-to-back with in_valid held; r1 = r1 + r2 would show duplication
    done_cnt = 0; instr_cnt = 0;
    do_instr("hold0", 4'd0, 2'd1, 2'd1, 2'd2, 8'h00, 1'b1);
    do_instr("hold1", 4'd0, 2'd1, 2'd1, 2'd2, 8'h00, 1'b1);
    do_instr("hold2", 4'd0, 2'd1, 2'd1, 2'd2, 8'h00, 1'b0);
    chk("hold.done_count", done_cnt, instr_cnt);

    // Randomized instructions
    for (int n = 0; n < 60; n++) begin
      logic [3:0] op;
      op = ($urandom_range(0, 9) < 9) ? 4'($urandom_range(0, 9)) : 4'($urandom_range(10, 15));
      do_instr($sformatf("rnd%0d", n), op, 2'($urandom), 2'($urandom), 2'($urandom),
               8'($urandom), 1'b0);
    end

    // Reset during EXEC of an ADD
    do_instr("pre_ldi", 4'd8, 2'd1, 2'd0, 2'd0, 8'h7F, 1'b0);
    in_valid = 1'b1; in_op = 4'd0; in_rd = 2'd2; in_rs1 = 2'd1; in_rs2 = 2'd1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_exec.done", 32'(done), 32'd0);
    rst_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    chk("rst_exec.after_done", 32'(done), 32'd0);
    chk_state("rst_exec");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
